// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: serializer FSM states and frame width.
// Also imported by the detector bench for its frame length.
package serial_pkg;

   localparam int SER_WIDTH = 32;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } ser_state_e;

endpackage

// File: rtl/shift_reg_piso.sv
// Loadable parallel-in/serial-out shift register.
// Clear wins over load, load wins over shift; vacated bits fill with zero.
module shift_reg_piso
   import serial_pkg::*;
#(
   parameter int WIDTH     = SER_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             sout_o
);

   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_d;

   // Next shifter contents: clear, parallel load or one-bit shift.
   always_comb begin
      sr_d = sr_q;
      if (clr_i) begin
         sr_d = '0;
      end else if (load_i) begin
         sr_d = data_i;
      end else if (shift_i) begin
         if (MSB_FIRST) begin
            sr_d = {sr_q[WIDTH-2:0], 1'b0};
         end else begin
            sr_d = {1'b0, sr_q[WIDTH-1:1]};
         end
      end
   end

   // Shifter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   // Serial bit comes straight from a flop, so dout is registered.
   assign sout_o = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/piso_serializer.sv
// Handshaked word serializer with a one-word holding buffer for
// gapless back-to-back streaming into the serial detector.
module piso_serializer
   import serial_pkg::*;
#(
   parameter int WIDTH     = SER_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             last_bit,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   ser_state_e       state_q, state_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;

   logic             xfer;
   logic             at_last;
   logic             sr_load;
   logic             sr_shift;
   logic             sr_clr;
   logic [WIDTH-1:0] sr_data;

   assign load_ready = !rst && !hold_full_q;
   assign xfer       = load_valid && load_ready;
   assign at_last    = (state_q == S_SHIFT) && (bit_cnt_q == CNT_LAST);

   assign dout_valid = (state_q == S_SHIFT);
   assign last_bit   = at_last;
   assign busy       = (state_q == S_SHIFT) || hold_full_q;

   // Next-state, counter, holding buffer and shifter controls.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      sr_load     = 1'b0;
      sr_shift    = 1'b0;
      sr_clr      = 1'b0;
      sr_data     = load_data;
      unique case (state_q)
         S_IDLE: begin
            if (xfer) begin
               sr_load   = 1'b1;
               bit_cnt_d = '0;
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (at_last) begin
               bit_cnt_d = '0;
               if (hold_full_q) begin
                  sr_load     = 1'b1;
                  sr_data     = hold_q;
                  hold_full_d = 1'b0;
               end else if (xfer) begin
                  sr_load = 1'b1;
               end else begin
                  sr_clr  = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               sr_shift  = 1'b1;
               bit_cnt_d = bit_cnt_q + CNT_ONE;
               if (xfer) begin
                  hold_d      = load_data;
                  hold_full_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control registers; reset drops any partial or held word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
      end
   end

   shift_reg_piso #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_sr (
      .clk     (clk),
      .rst     (rst),
      .load_i  (sr_load),
      .shift_i (sr_shift),
      .clr_i   (sr_clr),
      .data_i  (sr_data),
      .sout_o  (dout)
   );

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: a 32-bit MSB-first instance
// and an 8-bit LSB-first instance sharing clock and reset.
module tb_piso_serializer;

   logic        clk = 1'b0;
   logic        rst;

   logic [31:0] a_data;
   logic        a_valid, a_ready, a_dout, a_dvalid, a_last, a_busy;

   logic [7:0]  b_data;
   logic        b_valid, b_ready, b_dout, b_dvalid, b_last, b_busy;

   int pass_cnt = 0;
   int total    = 0;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(32), .MSB_FIRST(1'b1)) dut_a (
      .clk        (clk),
      .rst        (rst),
      .load_data  (a_data),
      .load_valid (a_valid),
      .load_ready (a_ready),
      .dout       (a_dout),
      .dout_valid (a_dvalid),
      .last_bit   (a_last),
      .busy       (a_busy)
   );

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .load_data  (b_data),
      .load_valid (b_valid),
      .load_ready (b_ready),
      .dout       (b_dout),
      .dout_valid (b_dvalid),
      .last_bit   (b_last),
      .busy       (b_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] w;
      logic [63:0] s;
      logic [7:0]  bw;
      logic        seen;

      rst     = 1'b1;
      a_data  = '0;
      a_valid = 1'b0;
      b_data  = '0;
      b_valid = 1'b0;

      // Reset for two edges
      step();
      step();
      check("rst_dout", a_dout, 0);
      check("rst_dvalid", a_dvalid, 0);
      check("rst_busy", a_busy, 0);
      check("rst_last", a_last, 0);
      check("rst_ready", a_ready, 0);
      check("rst_b_dvalid", b_dvalid, 0);
      rst = 1'b0;
      #1;
      check("rel_ready", a_ready, 1);
      check("rel_b_ready", b_ready, 1);

      // Single word
      w = 32'h36E1_7A0D;
      a_data  = w;
      a_valid = 1'b1;
      step();
      a_valid = 1'b0;
      for (int i = 0; i < 32; i++) begin
         check($sformatf("single_bit%0d", i), a_dout, w[31-i]);
         check($sformatf("single_val%0d", i), a_dvalid, 1);
         check($sformatf("single_last%0d", i), a_last, (i == 31));
         step();
      end
      check("single_end_val", a_dvalid, 0);
      check("single_end_dout", a_dout, 0);
      check("single_end_busy", a_busy, 0);

      // Back-to-back through the holding buffer
      s = {32'hFFFF_0000, 32'h0000_FFFF};
      a_data  = 32'hFFFF_0000;
      a_valid = 1'b1;
      step();
      check("b2b_bit0", a_dout, s[63]);
      check("b2b_ready0", a_ready, 1);
      a_data = 32'h0000_FFFF;
      step();
      a_valid = 1'b0;
      check("b2b_busy", a_busy, 1);
      for (int i = 1; i < 64; i++) begin
         check($sformatf("b2b_bit%0d", i), a_dout, s[63-i]);
         check($sformatf("b2b_val%0d", i), a_dvalid, 1);
         check($sformatf("b2b_rdy%0d", i), a_ready, (i >= 32));
         check($sformatf("b2b_last%0d", i), a_last,
               (i == 31 || i == 63));
         step();
      end
      check("b2b_end_val", a_dvalid, 0);

      // Reload on the last_bit edge with the holding buffer empty
      a_data  = 32'h8000_0001;
      a_valid = 1'b1;
      step();
      a_valid = 1'b0;
      for (int i = 0; i < 31; i++) step();
      check("same_last", a_last, 1);
      check("same_ready", a_ready, 1);
      check("same_lsb", a_dout, 1);
      a_data  = 32'hA5A5_A5A5;
      a_valid = 1'b1;
      step();
      a_valid = 1'b0;
      check("same_msb", a_dout, 1);
      check("same_val", a_dvalid, 1);
      check("same_notlast", a_last, 0);
      step();
      check("same_bit1", a_dout, 0);
      for (int i = 0; i < 30; i++) step();
      check("same_end_last", a_last, 1);
      check("same_end_bit", a_dout, 1);
      step();
      check("same_idle", a_dvalid, 0);

      // Reset mid-word with a word held
      w = 32'hDEAD_BEEF;
      a_data  = w;
      a_valid = 1'b1;
      step();
      a_data = 32'h1234_5678;
      step();
      a_valid = 1'b0;
      for (int i = 0; i < 9; i++) step();
      check("mid_bit10", a_dout, w[21]);
      check("mid_busy", a_busy, 1);
      check("mid_ready", a_ready, 0);
      rst = 1'b1;
      step();
      check("mid_rst_val", a_dvalid, 0);
      check("mid_rst_busy", a_busy, 0);
      check("mid_rst_dout", a_dout, 0);
      check("mid_rst_ready", a_ready, 0);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         seen = seen | a_dvalid | a_busy;
         step();
      end
      check("mid_no_resume", seen, 0);

      // LSB-first, 8-bit instance
      bw = 8'b0000_1101;
      b_data  = bw;
      b_valid = 1'b1;
      step();
      b_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("lsb_bit%0d", i), b_dout, bw[i]);
         check($sformatf("lsb_val%0d", i), b_dvalid, 1);
         check($sformatf("lsb_last%0d", i), b_last, (i == 7));
         step();
      end
      check("lsb_end_val", b_dvalid, 0);
      check("lsb_end_busy", b_busy, 0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
